// File: rtl/chan_stream_select.sv
// Channelizer output/bypass stage: steers raw samples into the core or straight to the output.
// Mode changes only on packet boundaries. The output is a 2-entry registered skid buffer with 1-cycle latency.
module chan_stream_select #(
    parameter int DATA_W    = 32,
    parameter int USER_W    = 16,
    parameter int CHAN_W    = 8,
    parameter int LEN_W     = 16,
    parameter int DRAIN_CYC = 64
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              s_raw_tvalid,
    input  logic [DATA_W-1:0] s_raw_tdata,
    output logic              s_raw_tready,
    output logic              c_in_tvalid,
    output logic [DATA_W-1:0] c_in_tdata,
    input  logic              c_in_tready,
    input  logic              c_out_tvalid,
    input  logic [DATA_W-1:0] c_out_tdata,
    input  logic [USER_W-1:0] c_out_tuser,
    input  logic              c_out_tlast,
    output logic              c_out_tready,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [USER_W-1:0] m_axis_tuser,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    input  logic              cfg_bypass,
    input  logic [LEN_W-1:0]  cfg_byp_pkt_len,
    input  logic [CHAN_W-1:0] cfg_chan_first_num,
    output logic              first_channel,
    output logic [1:0]        mode_state
);
    localparam int BEAT_W = DATA_W + USER_W + 2;
    localparam int IDLE_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        ST_CHAN  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_BYP   = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] out_q, skid_q, in_beat;
    logic              out_vld_q, skid_vld_q;
    logic [IDLE_W-1:0] idle_q;
    logic              last_tlast_q;
    logic [LEN_W-1:0]  byp_cnt_q, byp_len_q, len_cfg, len_eff;
    logic              up_rdy, in_vld, acc, byp_sel, byp_last, core_acc;

    // Upstream ready depends only on skid occupancy, never on m_axis_tready.
    assign up_rdy   = !skid_vld_q && !sync_reset;
    assign len_cfg  = (cfg_byp_pkt_len == '0) ? LEN_W'(1) : cfg_byp_pkt_len;
    assign len_eff  = (byp_cnt_q == '0) ? len_cfg : byp_len_q;
    assign byp_last = (byp_cnt_q == len_eff - LEN_W'(1));
    assign byp_sel  = (state_q == ST_BYP) || (state_q == ST_FIN);
    assign acc      = in_vld && up_rdy;
    assign core_acc = c_out_tvalid && c_out_tready;

    assign c_in_tdata = s_raw_tdata;
    assign in_beat = byp_sel ?
        {s_raw_tdata, {USER_W{1'b0}}, byp_last, 1'b0} :
        {c_out_tdata, c_out_tuser, c_out_tlast, (c_out_tuser[CHAN_W-1:0] == cfg_chan_first_num)};

    always_comb begin
        state_d      = state_q;
        in_vld       = 1'b0;
        c_in_tvalid  = 1'b0;
        s_raw_tready = 1'b0;
        c_out_tready = 1'b0;
        case (state_q)
            ST_CHAN: begin
                c_in_tvalid  = s_raw_tvalid && !sync_reset;
                s_raw_tready = c_in_tready && !sync_reset;
                c_out_tready = up_rdy;
                in_vld       = c_out_tvalid;
                if (cfg_bypass) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                c_out_tready = up_rdy;
                in_vld       = c_out_tvalid;
                // Leave only when the core is idle and its last beat closed a packet.
                if (!cfg_bypass) state_d = ST_CHAN;
                else if (idle_q == IDLE_MAX && last_tlast_q && !c_out_tvalid) state_d = ST_BYP;
            end
            ST_BYP: begin
                s_raw_tready = up_rdy;
                in_vld       = s_raw_tvalid;
                if (!cfg_bypass) state_d = (byp_cnt_q == '0) ? ST_CHAN : ST_FIN;
            end
            ST_FIN: begin
                // Only the remainder of the open packet is taken; no new packet starts here.
                s_raw_tready = up_rdy && (byp_cnt_q != '0);
                in_vld       = s_raw_tvalid && (byp_cnt_q != '0);
                if (cfg_bypass) state_d = ST_BYP;
                else if (byp_cnt_q == '0 || (s_raw_tvalid && s_raw_tready && byp_last)) state_d = ST_CHAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q      <= ST_CHAN;
            out_q        <= '0;
            skid_q       <= '0;
            out_vld_q    <= 1'b0;
            skid_vld_q   <= 1'b0;
            idle_q       <= '0;
            last_tlast_q <= 1'b1;
            byp_cnt_q    <= '0;
            byp_len_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != ST_DRAIN || c_out_tvalid) idle_q <= '0;
            else if (idle_q != IDLE_MAX) idle_q <= idle_q + IDLE_W'(1);
            if (core_acc) last_tlast_q <= c_out_tlast;
            if (acc && byp_sel) begin
                if (byp_cnt_q == '0) byp_len_q <= len_cfg;
                byp_cnt_q <= byp_last ? '0 : byp_cnt_q + LEN_W'(1);
            end
            if (!out_vld_q || m_axis_tready) begin
                if (skid_vld_q) begin
                    out_q      <= skid_q;
                    out_vld_q  <= 1'b1;
                    skid_vld_q <= 1'b0;
                end else begin
                    out_vld_q <= acc;
                    if (acc) out_q <= in_beat;
                end
            end else if (acc) begin
                skid_q     <= in_beat;
                skid_vld_q <= 1'b1;
            end
        end
    end

    assign {m_axis_tdata, m_axis_tuser, m_axis_tlast, first_channel} = out_q;
    assign m_axis_tvalid = out_vld_q;
    assign mode_state    = state_q;
endmodule
